// File: rtl/uart_rx_framer_pkg.sv
// uart_pkg: shared types and helpers for the UART receive path.
// Holds the receiver state encoding, default frame geometry and the
// 2-of-3 vote used when UART_RX_MAJORITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVS_DEF     = 16;
    localparam int NUM_BIT_DEF = 10;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_framer_baud_tick.sv
// uart_baud_tick: oversample tick generator.
// The divider register only follows div while load is high, so a caller can
// freeze the bit rate for the duration of a frame. div=0 behaves like div=1.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic [DIV_W-1:0] div,
    input  logic             load,
    output logic             tick
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] last;

    assign last = (div_q == '0) ? '0 : div_q - DIV_W'(1);
    // >= rather than == so a shrinking divider can never strand the counter
    assign tick = (cnt >= last);

    // Divider register and free-running tick counter
    always_ff @(posedge clk) begin
        if (RST) begin
            div_q <= div;
            cnt   <= '0;
        end else begin
            if (load) begin
                div_q <= div;
            end
            cnt <= tick ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampling UART receive front end.
// Synchronises rx_in, qualifies the start bit, samples every bit near its
// centre and emits the whole frame (start, data LSB-first, stop) with a
// one-cycle frame_valid strobe.
// Optional macro UART_RX_MAJORITY_EN: each bit is a 2-of-3 vote over the
// ticks at phase OVS/2-1, OVS/2, OVS/2+1 instead of a single centre sample.
module uart_rx_framer
    import uart_pkg::*;
#(
    parameter int NUM_BIT = NUM_BIT_DEF,
    parameter int OVS     = OVS_DEF,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               rx_in,
    input  logic [DIV_W-1:0]   div,
    output logic [NUM_BIT-1:0] frame_q,
    output logic               frame_valid,
    output logic               frame_err,
    output logic               busy
);

    localparam int PH_W = $clog2(OVS);
    localparam int BI_W = $clog2(NUM_BIT);
    localparam int DW   = NUM_BIT - 2;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVS - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [PH_W-1:0] PH_S0  = PH_W'(OVS / 2 - 1);
    localparam logic [PH_W-1:0] PH_S1  = PH_W'(OVS / 2);
    localparam logic [PH_W-1:0] PH_DEC = PH_W'(OVS / 2 + 1);
`else
    localparam logic [PH_W-1:0] PH_DEC = PH_W'(OVS / 2);
`endif
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(NUM_BIT - 3);

    rx_state_t       state, state_n;
    logic            rx_s1, rxs;
    logic            tick, idle, samp, bit_val;
    logic            ph_clr, bit_clr, bit_inc, capture, emit;
    logic [PH_W-1:0] ph;
    logic [BI_W-1:0] bit_idx;
    logic [DW-1:0]   data;

    assign idle = (state == IDLE);
    assign busy = ~idle;
    assign samp = tick && (ph == PH_DEC);

    // Two-flop synchroniser; idles high so reset cannot fake a start edge
    always_ff @(posedge clk) begin
        if (RST) begin
            rx_s1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            rx_s1 <= rx_in;
            rxs   <= rx_s1;
        end
    end

    uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
        .clk  (clk),
        .RST  (RST),
        .div  (div),
        .load (idle),
        .tick (tick)
    );

`ifdef UART_RX_MAJORITY_EN
    logic s0, s1;

    // Capture the two early votes; the third is rxs on the deciding tick
    always_ff @(posedge clk) begin
        if (tick && (ph == PH_S0)) s0 <= rxs;
        if (tick && (ph == PH_S1)) s1 <= rxs;
    end

    assign bit_val = majority3(s0, s1, rxs);
`else
    assign bit_val = rxs;
`endif

    // Next-state and per-cycle control decisions
    always_comb begin
        state_n = state;
        ph_clr  = 1'b0;
        bit_clr = 1'b0;
        bit_inc = 1'b0;
        capture = 1'b0;
        emit    = 1'b0;
        case (state)
            IDLE: begin
                if (tick && !rxs) begin
                    state_n = START;
                    ph_clr  = 1'b1;
                end
            end
            START: begin
                if (samp && bit_val) begin
                    state_n = IDLE;
                    ph_clr  = 1'b1;
                end else if (tick && (ph == PH_LAST)) begin
                    state_n = DATA;
                    ph_clr  = 1'b1;
                    bit_clr = 1'b1;
                end
            end
            DATA: begin
                capture = samp;
                if (tick && (ph == PH_LAST)) begin
                    ph_clr = 1'b1;
                    if (bit_idx == BI_LAST) begin
                        state_n = STOP;
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
            STOP: begin
                if (samp) begin
                    emit    = 1'b1;
                    ph_clr  = 1'b1;
                    state_n = bit_val ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_n = IDLE;
                    ph_clr  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                ph_clr  = 1'b1;
            end
        endcase
    end

    // State, bit-phase, bit index and output registers
    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= IDLE;
            ph          <= '0;
            bit_idx     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_q     <= '0;
        end else begin
            state <= state_n;
            if (ph_clr) begin
                ph <= '0;
            end else if (tick) begin
                ph <= (ph == PH_LAST) ? '0 : ph + PH_W'(1);
            end
            if (bit_clr) begin
                bit_idx <= '0;
            end else if (bit_inc) begin
                bit_idx <= bit_idx + BI_W'(1);
            end
            frame_valid <= emit;
            if (emit) begin
                frame_q   <= {bit_val, data, 1'b0};
                frame_err <= ~bit_val;
            end
        end
    end

    // LSB-first data shift register: the first data bit ends up in data[0]
    always_ff @(posedge clk) begin
        if (capture) begin
            data <= {bit_val, data[DW-1:1]};
        end
    end

endmodule

// File: doc/uart_rx_framer.md
Name: uart_rx_framer

Overview:
- Oversampling UART receive front end. It synchronises the serial line, detects and validates the start bit, and samples each bit at its centre.
- Assembles one complete frame of NUM_BIT bits (start + data + stop), LSB-first, and presents it as a parallel word with a one-cycle valid strobe.
- Sits directly upstream of the frame holding register (d_reg, NUM_BIT=10), which captures frame_q on frame_valid.

Parameters:
- NUM_BIT, 10, total frame width including start and stop bits (data bits = NUM_BIT-2)
- OVS, 16, oversample ticks per bit period (even, >= 4)
- DIV_W, 16, width of the clock-divider input

Ports:
- clk  in  1  system clock
- RST  in  1  synchronous reset, active-high
- rx_in  in  1  asynchronous serial line, idle high
- div  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1
- frame_q  out  NUM_BIT  received frame: [0]=start, [NUM_BIT-2:1]=data LSB-first, [NUM_BIT-1]=stop
- frame_valid  out  1  one-cycle strobe; frame_q/frame_err are valid in this cycle
- frame_err  out  1  stop bit sampled 0; valid with frame_valid, held until the next frame
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (RST=1 at posedge clk):
  - frame_q=0, frame_valid=0, frame_err=0, busy=0.
  - Both synchroniser flops=1; tick counter=0; state=IDLE.
  - Reset overrides everything, including mid-frame; no partial frame is emitted.
- Synchroniser: 2-flop chain on rx_in. All decisions use the second-stage output rxs (2-cycle latency).
- Tick generator:
  - Counter runs 0..D-1, where D=max(div,1). tick=1 in the cycle the counter equals D-1; the counter then wraps to 0.
  - div is latched into the divider register only while in IDLE, so a mid-frame div change takes effect from the next frame.
- Bit-phase counter ph (0..OVS-1): advances on tick, cleared on every state entry.
- State machine (enum, in package):
  - IDLE: on tick with rxs=0, go to START, ph=0.
  - START: at ph=OVS/2, sample. If the sample is 1 (false start), go to IDLE. At ph=OVS-1 with tick, go to DATA, bit index=0.
  - DATA: sample at ph=OVS/2 and shift into shift register position bit_idx+1. At ph=OVS-1 with tick, increment bit_idx. After NUM_BIT-2 bits, go to STOP.
  - STOP: sample at ph=OVS/2.
    - Next cycle: frame_valid=1 and frame_q={stop_sample, data, 1'b0}; frame_err=~stop_sample.
    - If stop_sample=1, go to IDLE.
    - If stop_sample=0, go to BREAK.
  - BREAK: busy=1; stay until rxs=1, then go to IDLE. No start detection while in BREAK.
- Latency: frame_valid rises exactly 1 clk after the tick on which the stop bit is sampled (no majority) or decided (majority).
- frame_valid is never asserted for two consecutive cycles.
- Back-to-back frames: a start edge detected on the first tick in IDLE after STOP is accepted. There is no dead time beyond the remaining half stop bit.
- frame_q holds its value between strobes.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
  - Defined: each bit is sampled on ticks at ph=OVS/2-1, OVS/2 and OVS/2+1, and the bit value is the 2-of-3 majority, decided at ph=OVS/2+1. The false-start check uses the majority value. frame_valid follows the ph=OVS/2+1 tick of the stop bit.
  - Undefined: a single sample at ph=OVS/2.

Decomposition:
- Package uart_pkg holds:
  - typedef enum rx_state_t {IDLE, START, DATA, STOP, BREAK}
  - localparam defaults for OVS and NUM_BIT
  - helper function majority3
- Sub-module uart_baud_tick: divider register plus counter, producing tick; reused later by the TX path.

Test Plan:
- div=4, OVS=16 (64 clk/bit); send data 0x55 with stop=1 -> single frame_valid pulse, frame_q=10'h2AA, frame_err=0, busy falls the same cycle state returns to IDLE.
- Data 0xA3 with stop bit driven 0, line held low 3 more bit times -> frame_q=10'h146, frame_err=1. busy stays 1 until rxs=1; no second frame_valid during the low period.
- rx_in low for 12 clk (3 ticks), then high -> no frame_valid, busy high for at most ~36 clk then back to 0.
- Two frames 0x00 then 0xFF with one stop bit and no idle gap -> frame_q=10'h200 then 10'h3FE, strobes exactly 640 clk apart.
- RST pulsed for 1 cycle during data bit 4 of a frame -> all outputs 0 the next cycle. The tail of the interrupted frame produces no frame_valid. The next clean 0x3C frame gives frame_q=10'h278.
- 4-clk (1-tick) low glitch centred on data bit 2 of 0xFF -> with UART_RX_MAJORITY_EN, frame_q=10'h3FE; without it, frame_q=10'h3F6.
